// File: rtl/z80fi_bus_recorder.sv
// Accumulates the T-state-level bus activity of one instruction into a z80fi
// bus record and presents it for one cycle when the next instruction starts.
module z80fi_bus_recorder #(
    parameter int unsigned MAX_TCYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        insn_start,
    input  logic        m_start,
    input  logic [2:0]  m_type,
    input  logic        rd_strobe,
    input  logic        wr_strobe,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_rdata,
    input  logic [7:0]  bus_wdata,
    output logic        z80fi_valid,
    output logic [2:0]  z80fi_mcycle_type1,
    output logic [2:0]  z80fi_mcycle_type2,
    output logic [2:0]  z80fi_mcycle_type3,
    output logic [2:0]  z80fi_mcycle_type4,
    output logic [2:0]  z80fi_mcycle_type5,
    output logic [2:0]  z80fi_mcycle_type6,
    output logic [3:0]  z80fi_tcycles1,
    output logic [3:0]  z80fi_tcycles2,
    output logic [3:0]  z80fi_tcycles3,
    output logic [3:0]  z80fi_tcycles4,
    output logic [3:0]  z80fi_tcycles5,
    output logic [3:0]  z80fi_tcycles6,
    output logic [15:0] z80fi_bus_raddr,
    output logic [15:0] z80fi_bus_raddr2,
    output logic [7:0]  z80fi_bus_rdata,
    output logic [7:0]  z80fi_bus_rdata2,
    output logic [15:0] z80fi_bus_waddr,
    output logic [15:0] z80fi_bus_waddr2,
    output logic [7:0]  z80fi_bus_wdata,
    output logic [7:0]  z80fi_bus_wdata2,
    output logic [3:0]  z80fi_bus_used,
    output logic        z80fi_overflow
);

    localparam int unsigned NUM_M = 6;
    localparam int unsigned TW    = 4;
    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 8;
    localparam int unsigned MTW   = 3;
    localparam int unsigned IW    = 3;

    // M-cycle codes shared with z80.vh
    localparam logic [MTW-1:0] CYCLE_NONE = 3'd0;
    localparam logic [MTW-1:0] CYCLE_M1   = 3'd1;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_RECORD = 1'b1;

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_M - 1);
    localparam logic [TW-1:0] TSAT     = TW'(MAX_TCYCLES);

    logic [0:0]     r_state;
    logic [0:0]     w_state_nxt;
    logic           w_restart;
    logic           w_commit;
    logic           w_new_m;
    logic           w_m_ovf;
    logic           w_tick;
    logic           w_rd_take;
    logic           w_wr_take;
    logic [MTW-1:0] w_cur_type;

    // Accumulators for the instruction in progress
    logic [IW-1:0]  r_idx;
    logic [MTW-1:0] r_type [NUM_M];
    logic [TW-1:0]  r_tc   [NUM_M];
    logic [MTW-1:0] r_cur_type;
    logic           r_mfrozen;
    logic [AW-1:0]  r_raddr, r_raddr2, r_waddr, r_waddr2;
    logic [DW-1:0]  r_rdata, r_rdata2, r_wdata, r_wdata2;
    logic [3:0]     r_used;
    logic           r_ovf;

    // Committed record
    logic           r_o_valid;
    logic [MTW-1:0] r_o_type [NUM_M];
    logic [TW-1:0]  r_o_tc   [NUM_M];
    logic [AW-1:0]  r_o_raddr, r_o_raddr2, r_o_waddr, r_o_waddr2;
    logic [DW-1:0]  r_o_rdata, r_o_rdata2, r_o_wdata, r_o_wdata2;
    logic [3:0]     r_o_used;
    logic           r_o_ovf;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Decode what this T-state does to the record
    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        w_commit    = 1'b0;
        w_new_m     = 1'b0;
        w_m_ovf     = 1'b0;
        w_tick      = 1'b0;
        w_rd_take   = 1'b0;
        w_wr_take   = 1'b0;
        w_cur_type  = r_cur_type;
        case (r_state)
            S_IDLE: begin
                if (insn_start) begin
                    w_state_nxt = S_RECORD;
                    w_restart   = 1'b1;
                end
            end
            S_RECORD: begin
                if (insn_start) begin
                    w_commit  = 1'b1;
                    w_restart = 1'b1;
                end else begin
                    if (m_start) begin
                        w_cur_type = m_type;
                        if (r_mfrozen || (r_idx == LAST_IDX)) w_m_ovf = 1'b1;
                        else                                  w_new_m = 1'b1;
                    end else if (!r_mfrozen) begin
                        w_tick = 1'b1;
                    end
                    // Opcode fetch traffic is not bus data
                    if (w_cur_type != CYCLE_M1) begin
                        w_rd_take = rd_strobe;
                        w_wr_take = wr_strobe;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx      <= '0;
            r_cur_type <= CYCLE_NONE;
            r_mfrozen  <= 1'b0;
            for (int i = 0; i < NUM_M; i++) begin
                r_type[i] <= CYCLE_NONE;
                r_tc[i]   <= '0;
            end
            r_raddr  <= '0; r_raddr2 <= '0; r_waddr <= '0; r_waddr2 <= '0;
            r_rdata  <= '0; r_rdata2 <= '0; r_wdata <= '0; r_wdata2 <= '0;
            r_used   <= '0;
            r_ovf    <= 1'b0;
        end else if (w_restart) begin
            r_idx      <= '0;
            r_cur_type <= m_type;
            r_mfrozen  <= 1'b0;
            r_type[0]  <= m_type;
            r_tc[0]    <= TW'(1);
            for (int i = 1; i < NUM_M; i++) begin
                r_type[i] <= CYCLE_NONE;
                r_tc[i]   <= '0;
            end
            r_raddr  <= '0; r_raddr2 <= '0; r_waddr <= '0; r_waddr2 <= '0;
            r_rdata  <= '0; r_rdata2 <= '0; r_wdata <= '0; r_wdata2 <= '0;
            r_used   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_cur_type <= w_cur_type;
            if (w_new_m) begin
                r_idx                   <= r_idx + IW'(1);
                r_type[r_idx + IW'(1)]  <= m_type;
                r_tc[r_idx + IW'(1)]    <= TW'(1);
            end
            if (w_m_ovf) begin
                r_mfrozen <= 1'b1;
                r_ovf     <= 1'b1;
            end
            if (w_tick && (r_tc[r_idx] != TSAT)) r_tc[r_idx] <= r_tc[r_idx] + TW'(1);
            if (w_rd_take) begin
                if (!r_used[0]) begin
                    r_raddr   <= bus_addr;
                    r_rdata   <= bus_rdata;
                    r_used[0] <= 1'b1;
                end else if (!r_used[1]) begin
                    r_raddr2  <= bus_addr;
                    r_rdata2  <= bus_rdata;
                    r_used[1] <= 1'b1;
                end else begin
                    r_ovf <= 1'b1;
                end
            end
            if (w_wr_take) begin
                if (!r_used[2]) begin
                    r_waddr   <= bus_addr;
                    r_wdata   <= bus_wdata;
                    r_used[2] <= 1'b1;
                end else if (!r_used[3]) begin
                    r_waddr2  <= bus_addr;
                    r_wdata2  <= bus_wdata;
                    r_used[3] <= 1'b1;
                end else begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    // Output record: loaded on commit, held until the next one
    always_ff @(posedge clk) begin
        if (reset) begin
            r_o_valid <= 1'b0;
            for (int i = 0; i < NUM_M; i++) begin
                r_o_type[i] <= CYCLE_NONE;
                r_o_tc[i]   <= '0;
            end
            r_o_raddr <= '0; r_o_raddr2 <= '0; r_o_waddr <= '0; r_o_waddr2 <= '0;
            r_o_rdata <= '0; r_o_rdata2 <= '0; r_o_wdata <= '0; r_o_wdata2 <= '0;
            r_o_used  <= '0;
            r_o_ovf   <= 1'b0;
        end else begin
            r_o_valid <= w_commit;
            if (w_commit) begin
                for (int i = 0; i < NUM_M; i++) begin
                    r_o_type[i] <= r_type[i];
                    r_o_tc[i]   <= r_tc[i];
                end
                r_o_raddr  <= r_raddr;  r_o_raddr2 <= r_raddr2;
                r_o_waddr  <= r_waddr;  r_o_waddr2 <= r_waddr2;
                r_o_rdata  <= r_rdata;  r_o_rdata2 <= r_rdata2;
                r_o_wdata  <= r_wdata;  r_o_wdata2 <= r_wdata2;
                r_o_used   <= r_used;
                r_o_ovf    <= r_ovf;
            end
        end
    end

    assign z80fi_valid        = r_o_valid;
    assign z80fi_mcycle_type1 = r_o_type[0];
    assign z80fi_mcycle_type2 = r_o_type[1];
    assign z80fi_mcycle_type3 = r_o_type[2];
    assign z80fi_mcycle_type4 = r_o_type[3];
    assign z80fi_mcycle_type5 = r_o_type[4];
    assign z80fi_mcycle_type6 = r_o_type[5];
    assign z80fi_tcycles1     = r_o_tc[0];
    assign z80fi_tcycles2     = r_o_tc[1];
    assign z80fi_tcycles3     = r_o_tc[2];
    assign z80fi_tcycles4     = r_o_tc[3];
    assign z80fi_tcycles5     = r_o_tc[4];
    assign z80fi_tcycles6     = r_o_tc[5];
    assign z80fi_bus_raddr    = r_o_raddr;
    assign z80fi_bus_raddr2   = r_o_raddr2;
    assign z80fi_bus_rdata    = r_o_rdata;
    assign z80fi_bus_rdata2   = r_o_rdata2;
    assign z80fi_bus_waddr    = r_o_waddr;
    assign z80fi_bus_waddr2   = r_o_waddr2;
    assign z80fi_bus_wdata    = r_o_wdata;
    assign z80fi_bus_wdata2   = r_o_wdata2;
    assign z80fi_bus_used     = r_o_used;
    assign z80fi_overflow     = r_o_ovf;

endmodule
